// File: rtl/axi4_lite_reg_slave.sv
// AXI4-Lite register slave: R/W control registers, read-only status
// registers and a fixed ID word inside one 4 KB window.
module axi4_lite_reg_slave #(
    parameter int          NUM_CTRL   = 8,
    parameter int          NUM_STAT   = 8,
    parameter int          ADDR_W     = 40,
    parameter logic [31:0] CTRL_RESET = 32'h0000_0000,
    parameter logic [31:0] ID_VALUE   = 32'hC0DE_0001
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [ADDR_W-1:0]     s_awaddr,
    input  logic [2:0]            s_awprot,
    input  logic                  s_awvalid,
    output logic                  s_awready,
    input  logic [31:0]           s_wdata,
    input  logic [3:0]            s_wstrb,
    input  logic                  s_wvalid,
    output logic                  s_wready,
    output logic [1:0]            s_bresp,
    output logic                  s_bvalid,
    input  logic                  s_bready,
    input  logic [ADDR_W-1:0]     s_araddr,
    input  logic [2:0]            s_arprot,
    input  logic                  s_arvalid,
    output logic                  s_arready,
    output logic [31:0]           s_rdata,
    output logic [1:0]            s_rresp,
    output logic                  s_rvalid,
    input  logic                  s_rready,
    output logic [32*NUM_CTRL-1:0] ctrl_q,
    output logic [NUM_CTRL-1:0]   ctrl_wr,
    input  logic [32*NUM_STAT-1:0] stat_d
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] HIT_CTRL = 2'd0;
    localparam logic [1:0] HIT_STAT = 2'd1;
    localparam logic [1:0] HIT_ID   = 2'd2;
    localparam logic [1:0] HIT_NONE = 2'd3;

    // Classify a word offset (addr[11:2]); the ID word wins over the status range.
    function automatic logic [1:0] decode(input logic [9:0] off);
        logic [1:0] kind;
        if (off == 10'h3FF)
            kind = HIT_ID;
        else if (!off[9] && (off[8:0] < 9'(NUM_CTRL)))
            kind = HIT_CTRL;
        else if (off[9] && (off[8:0] < 9'(NUM_STAT)))
            kind = HIT_STAT;
        else
            kind = HIT_NONE;
        return kind;
    endfunction

    logic        aw_held;
    logic        w_held;
    logic [9:0]  aw_off_q;
    logic [31:0] w_data_q;
    logic [3:0]  w_strb_q;
    logic        aw_hs;
    logic        w_hs;
    logic        commit;
    logic [9:0]  wr_off;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic [1:0]  wr_kind;
    logic [31:0] ctrl_r [NUM_CTRL];

    logic        ar_hs;
    logic [9:0]  rd_off;
    logic [31:0] rd_data;
    logic [1:0]  rd_resp;

    // Protection bits, window-select bits and byte-lane bits play no part in decode.
    logic unused_ok;
    assign unused_ok = ^{s_awprot, s_arprot, s_awaddr[ADDR_W-1:12], s_araddr[ADDR_W-1:12],
                         s_awaddr[1:0], s_araddr[1:0]};

    assign s_awready = !aw_held && !s_bvalid;
    assign s_wready  = !w_held && !s_bvalid;
    assign aw_hs     = s_awvalid && s_awready;
    assign w_hs      = s_wvalid && s_wready;

    // A write commits on the edge that completes the AW/W pair.
    assign commit  = (aw_held || aw_hs) && (w_held || w_hs) && (aw_hs || w_hs);
    assign wr_off  = aw_hs ? s_awaddr[11:2] : aw_off_q;
    assign wr_data = w_hs ? s_wdata : w_data_q;
    assign wr_strb = w_hs ? s_wstrb : w_strb_q;
    assign wr_kind = decode(wr_off);

    for (genvar g = 0; g < NUM_CTRL; g++) begin : g_ctrl_out
        assign ctrl_q[32*g +: 32] = ctrl_r[g];
    end

    // Capture whichever half of the write pair arrives first.
    always_ff @(posedge aclk) begin
        if (aw_hs)
            aw_off_q <= s_awaddr[11:2];
        if (w_hs) begin
            w_data_q <= s_wdata;
            w_strb_q <= s_wstrb;
        end
    end

    // Holding flags and the write response channel.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            s_bvalid <= 1'b0;
            s_bresp  <= RESP_OKAY;
        end else if (commit) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            s_bvalid <= 1'b1;
            s_bresp  <= (wr_kind == HIT_CTRL) ? RESP_OKAY : RESP_SLVERR;
        end else begin
            if (aw_hs)
                aw_held <= 1'b1;
            if (w_hs)
                w_held <= 1'b1;
            if (s_bvalid && s_bready)
                s_bvalid <= 1'b0;
        end
    end

    // Control registers: bytewise update and a one-cycle write pulse per register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_CTRL; i++)
                ctrl_r[i] <= CTRL_RESET;
            ctrl_wr <= '0;
        end else begin
            ctrl_wr <= '0;
            for (int i = 0; i < NUM_CTRL; i++) begin
                if (commit && (wr_kind == HIT_CTRL) && (wr_off[8:0] == 9'(i))) begin
                    ctrl_wr[i] <= 1'b1;
                    for (int b = 0; b < 4; b++)
                        if (wr_strb[b])
                            ctrl_r[i][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    assign s_arready = !s_rvalid;
    assign ar_hs     = s_arvalid && s_arready;
    assign rd_off    = s_araddr[11:2];

    // Read data mux; unmapped offsets return zero with SLVERR.
    always_comb begin
        rd_data = '0;
        rd_resp = RESP_SLVERR;
        case (decode(rd_off))
            HIT_CTRL: begin
                rd_resp = RESP_OKAY;
                for (int i = 0; i < NUM_CTRL; i++)
                    if (rd_off[8:0] == 9'(i))
                        rd_data = ctrl_r[i];
            end
            HIT_STAT: begin
                rd_resp = RESP_OKAY;
                for (int i = 0; i < NUM_STAT; i++)
                    if (rd_off[8:0] == 9'(i))
                        rd_data = stat_d[32*i +: 32];
            end
            HIT_ID: begin
                rd_resp = RESP_OKAY;
                rd_data = ID_VALUE;
            end
            default: ;
        endcase
    end

    // Read response register; held stable until the master accepts it.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s_rvalid <= 1'b0;
            s_rdata  <= '0;
            s_rresp  <= RESP_OKAY;
        end else if (ar_hs) begin
            s_rvalid <= 1'b1;
            s_rdata  <= rd_data;
            s_rresp  <= rd_resp;
        end else if (s_rvalid && s_rready) begin
            s_rvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axi4_lite_reg_slave.sv
// Self-checking bench for axi4_lite_reg_slave with a register-map reference model.
module tb_axi4_lite_reg_slave;

    localparam int          NC   = 8;
    localparam int          NS   = 8;
    localparam logic [31:0] CRST = 32'h1234_5678;
    localparam logic [31:0] IDV  = 32'hC0DE_0001;

    logic            aclk = 1'b0;
    logic            aresetn = 1'b0;
    logic [39:0]     s_awaddr = '0;
    logic [2:0]      s_awprot = '0;
    logic            s_awvalid = 1'b0;
    logic            s_awready;
    logic [31:0]     s_wdata = '0;
    logic [3:0]      s_wstrb = '0;
    logic            s_wvalid = 1'b0;
    logic            s_wready;
    logic [1:0]      s_bresp;
    logic            s_bvalid;
    logic            s_bready = 1'b0;
    logic [39:0]     s_araddr = '0;
    logic [2:0]      s_arprot = '0;
    logic            s_arvalid = 1'b0;
    logic            s_arready;
    logic [31:0]     s_rdata;
    logic [1:0]      s_rresp;
    logic            s_rvalid;
    logic            s_rready = 1'b0;
    logic [32*NC-1:0] ctrl_q;
    logic [NC-1:0]   ctrl_wr;
    logic [32*NS-1:0] stat_d = '0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] ctrl_m [NC];
    logic [31:0] stat_m [NS];

    axi4_lite_reg_slave #(
        .NUM_CTRL(NC), .NUM_STAT(NS), .ADDR_W(40), .CTRL_RESET(CRST), .ID_VALUE(IDV)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_awaddr(s_awaddr), .s_awprot(s_awprot), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .ctrl_q(ctrl_q), .ctrl_wr(ctrl_wr), .stat_d(stat_d)
    );

    always #5 aclk = ~aclk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got running want finished");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] cq(input int i);
        return ctrl_q[32*i +: 32];
    endfunction

    task automatic set_stat(input int i, input logic [31:0] v);
        stat_m[i] = v;
        stat_d[32*i +: 32] = v;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NC; i++) ctrl_m[i] = CRST;
    endtask

    // Region of a byte address: 0 ctrl, 1 status, 2 ID, 3 unmapped.
    function automatic int region(input logic [39:0] a);
        int off;
        off = int'(a[11:0]) & 'hFFC;
        if (off == 'hFFC) return 2;
        if (off < 'h800) return (off / 4 < NC) ? 0 : 3;
        return ((off - 'h800) / 4 < NS) ? 1 : 3;
    endfunction

    function automatic logic [31:0] model_read(input logic [39:0] a);
        int off;
        off = int'(a[11:0]) & 'hFFC;
        case (region(a))
            0: return ctrl_m[off / 4];
            1: return stat_m[(off - 'h800) / 4];
            2: return IDV;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [1:0] model_resp(input logic [39:0] a, input bit is_write);
        int r;
        r = region(a);
        if (is_write) return (r == 0) ? 2'b00 : 2'b10;
        return (r == 3) ? 2'b10 : 2'b00;
    endfunction

    task automatic model_write(input logic [39:0] a, input logic [31:0] d, input logic [3:0] s);
        int idx;
        if (region(a) == 0) begin
            idx = (int'(a[11:0]) & 'hFFC) / 4;
            for (int b = 0; b < 4; b++)
                if (s[b]) ctrl_m[idx][8*b +: 8] = d[8*b +: 8];
        end
    endtask

    task automatic do_write(input logic [39:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp, output bit ok);
        bit aw_done, w_done, af, wf;
        int n;
        aw_done = 0; w_done = 0; n = 0; resp = 2'bxx;
        s_awaddr = a; s_awvalid = 1; s_wdata = d; s_wstrb = s; s_wvalid = 1;
        while (!(aw_done && w_done) && n < 20) begin
            af = s_awvalid && s_awready;
            wf = s_wvalid && s_wready;
            @(posedge aclk); #1;
            n++;
            if (af) begin aw_done = 1; s_awvalid = 0; end
            if (wf) begin w_done = 1; s_wvalid = 0; end
        end
        s_awvalid = 0; s_wvalid = 0;
        ok = aw_done && w_done;
        n = 0;
        while (ok && !s_bvalid && n < 20) begin @(posedge aclk); #1; n++; end
        if (!s_bvalid) ok = 0;
        else begin
            resp = s_bresp;
            s_bready = 1;
            @(posedge aclk); #1;
            s_bready = 0;
        end
    endtask

    task automatic do_read(input logic [39:0] a, output logic [31:0] d, output logic [1:0] resp,
                           output bit ok, output bit lat1);
        int n;
        n = 0; d = 'x; resp = 'x; lat1 = 0;
        s_araddr = a; s_arprot = 3'($urandom); s_arvalid = 1;
        while (!s_arready && n < 20) begin @(posedge aclk); #1; n++; end
        ok = s_arready;
        @(posedge aclk); #1;
        s_arvalid = 0;
        lat1 = s_rvalid;
        n = 0;
        while (ok && !s_rvalid && n < 20) begin @(posedge aclk); #1; n++; end
        if (!s_rvalid) ok = 0;
        else begin
            d = s_rdata; resp = s_rresp;
            s_rready = 1;
            @(posedge aclk); #1;
            s_rready = 0;
        end
    endtask

    task automatic test_reset();
        logic [31:0] d; logic [1:0] r; bit ok, lat;
        repeat (5) @(posedge aclk);
        #1;
        n_checks++;
        if ({s_bvalid, s_rvalid, ctrl_wr} !== '0) begin
            n_fail++; $display("FAIL reset_valids: got b=%b r=%b wr=%b want 0", s_bvalid, s_rvalid, ctrl_wr);
        end
        for (int i = 0; i < NC; i++) begin
            n_checks++;
            if (cq(i) !== CRST) begin
                n_fail++; $display("FAIL reset_ctrl%0d: got %h want %h", i, cq(i), CRST);
            end
        end
        aresetn = 1;
        @(posedge aclk); #1;
        n_checks++;
        if ({s_awready, s_wready, s_arready} !== 3'b111) begin
            n_fail++; $display("FAIL reset_ready: got %b want 111", {s_awready, s_wready, s_arready});
        end
        do_read(40'hAB_0000_0FFC, d, r, ok, lat);
        n_checks++;
        if (!ok || d !== IDV || r !== 2'b00) begin
            n_fail++; $display("FAIL id_read: got %h/%0d ok=%0d want %h/0", d, r, ok, IDV);
        end
    endtask

    task automatic test_write_readback();
        logic [31:0] d; logic [1:0] r; bit ok, lat;
        s_awaddr = 40'h8; s_wdata = 32'hA5A5_5A5A; s_wstrb = 4'hF;
        s_awvalid = 1; s_wvalid = 1;
        @(posedge aclk); #1;
        s_awvalid = 0; s_wvalid = 0;
        model_write(40'h8, 32'hA5A5_5A5A, 4'hF);
        n_checks++;
        if (s_bvalid !== 1'b1 || s_bresp !== 2'b00) begin
            n_fail++; $display("FAIL wr_bvalid: got v=%b resp=%0d want 1/0", s_bvalid, s_bresp);
        end
        n_checks++;
        if (ctrl_wr !== 8'b0000_0100) begin
            n_fail++; $display("FAIL wr_pulse: got %b want 00000100", ctrl_wr);
        end
        n_checks++;
        if (cq(2) !== 32'hA5A5_5A5A) begin
            n_fail++; $display("FAIL wr_ctrl2: got %h want a5a55a5a", cq(2));
        end
        s_bready = 1;
        @(posedge aclk); #1;
        s_bready = 0;
        n_checks++;
        if (ctrl_wr !== '0 || s_bvalid !== 1'b0) begin
            n_fail++; $display("FAIL wr_pulse_end: got wr=%b b=%b want 0/0", ctrl_wr, s_bvalid);
        end
        do_read(40'h8, d, r, ok, lat);
        n_checks++;
        if (!ok || !lat || d !== 32'hA5A5_5A5A || r !== 2'b00) begin
            n_fail++; $display("FAIL readback: got %h/%0d lat=%0d want a5a55a5a/0 lat=1", d, r, lat);
        end
    endtask

    task automatic test_decoupled();
        logic [1:0] r; bit ok;
        do_write(40'h4, 32'hFFFF_FF00, 4'hF, r, ok);
        model_write(40'h4, 32'hFFFF_FF00, 4'hF);
        n_checks++;
        if (!ok || r !== 2'b00) begin
            n_fail++; $display("FAIL dec_prewrite: got ok=%0d resp=%0d want 1/0", ok, r);
        end
        s_wdata = 32'h0000_00FF; s_wstrb = 4'h1; s_wvalid = 1;
        @(posedge aclk); #1;
        s_wvalid = 0;
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if ({s_wready, s_bvalid} !== 2'b00 || cq(1) !== 32'hFFFF_FF00) begin
                n_fail++; $display("FAIL dec_wait%0d: got wready=%b bvalid=%b q=%h want 0/0/ffffff00",
                                   c, s_wready, s_bvalid, cq(1));
            end
            @(posedge aclk); #1;
        end
        s_awaddr = 40'h4; s_awvalid = 1;
        @(posedge aclk); #1;
        s_awvalid = 0;
        model_write(40'h4, 32'h0000_00FF, 4'h1);
        n_checks++;
        if (s_bvalid !== 1'b1 || s_bresp !== 2'b00 || cq(1) !== ctrl_m[1] || ctrl_wr !== 8'b10) begin
            n_fail++; $display("FAIL dec_commit: got b=%b resp=%0d q=%h wr=%b want 1/0/%h/00000010",
                               s_bvalid, s_bresp, cq(1), ctrl_wr, ctrl_m[1]);
        end
        s_bready = 1;
        @(posedge aclk); #1;
        s_bready = 0;
    endtask

    task automatic test_back_pressure();
        logic [31:0] d1, d2, v1; logic [1:0] r; bit ok, lat;
        d1 = $urandom; d2 = $urandom;
        s_awaddr = 40'hC; s_wdata = d1; s_wstrb = 4'hF; s_awvalid = 1; s_wvalid = 1;
        @(posedge aclk); #1;
        model_write(40'hC, d1, 4'hF);
        s_awaddr = 40'h10; s_wdata = d2;
        for (int c = 0; c < 5; c++) begin
            if (c == 4) s_bready = 1;
            n_checks++;
            if ({s_bvalid, s_awready, s_wready} !== 3'b100) begin
                n_fail++; $display("FAIL bp_hold%0d: got b/aw/w=%b want 100", c, {s_bvalid, s_awready, s_wready});
            end
            @(posedge aclk); #1;
        end
        s_bready = 0;
        n_checks++;
        if ({s_bvalid, s_awready, s_wready} !== 3'b011 || cq(4) !== ctrl_m[4]) begin
            n_fail++; $display("FAIL bp_release: got b/aw/w=%b q4=%h want 011/%h",
                               {s_bvalid, s_awready, s_wready}, cq(4), ctrl_m[4]);
        end
        @(posedge aclk); #1;
        s_awvalid = 0; s_wvalid = 0;
        model_write(40'h10, d2, 4'hF);
        n_checks++;
        if (s_bvalid !== 1'b1 || cq(4) !== d2 || cq(3) !== d1) begin
            n_fail++; $display("FAIL bp_second: got b=%b q4=%h q3=%h want 1/%h/%h", s_bvalid, cq(4), cq(3), d2, d1);
        end
        s_bready = 1;
        @(posedge aclk); #1;
        s_bready = 0;
        v1 = $urandom;
        set_stat(2, v1);
        s_araddr = 40'h808; s_arvalid = 1;
        @(posedge aclk); #1;
        s_arvalid = 0;
        for (int c = 0; c < 5; c++) begin
            set_stat(2, $urandom);
            n_checks++;
            if (s_rvalid !== 1'b1 || s_rdata !== v1 || s_rresp !== 2'b00 || s_arready !== 1'b0) begin
                n_fail++; $display("FAIL r_stall%0d: got v=%b d=%h resp=%0d want 1/%h/0", c, s_rvalid, s_rdata, s_rresp, v1);
            end
            @(posedge aclk); #1;
        end
        s_rready = 1;
        @(posedge aclk); #1;
        s_rready = 0;
        n_checks++;
        if (s_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL r_release: got rvalid=%b want 0", s_rvalid);
        end
        do_read(40'h808, d1, r, ok, lat);
        n_checks++;
        if (!ok || d1 !== stat_m[2]) begin
            n_fail++; $display("FAIL stat_live: got %h want %h", d1, stat_m[2]);
        end
    endtask

    task automatic test_errors();
        logic [31:0] d; logic [1:0] r; bit ok, lat; bit same;
        do_write(40'h800, $urandom, 4'hF, r, ok);
        n_checks++;
        if (!ok || r !== 2'b10) begin
            n_fail++; $display("FAIL err_wr800: got ok=%0d resp=%0d want 1/2", ok, r);
        end
        same = 1;
        for (int i = 0; i < NC; i++) if (cq(i) !== ctrl_m[i]) same = 0;
        n_checks++;
        if (!same) begin
            n_fail++; $display("FAIL err_ctrl_kept: got %h want %h (reg0)", cq(0), ctrl_m[0]);
        end
        do_read(40'h800, d, r, ok, lat);
        n_checks++;
        if (!ok || d !== stat_m[0] || r !== 2'b00) begin
            n_fail++; $display("FAIL err_stat_kept: got %h/%0d want %h/0", d, r, stat_m[0]);
        end
        do_read(40'h400, d, r, ok, lat);
        n_checks++;
        if (!ok || d !== 32'h0 || r !== 2'b10) begin
            n_fail++; $display("FAIL err_rd400: got %h/%0d want 0/2", d, r);
        end
        do_write(40'hFFC, $urandom, 4'hF, r, ok);
        n_checks++;
        if (!ok || r !== 2'b10) begin
            n_fail++; $display("FAIL err_wrFFC: got ok=%0d resp=%0d want 1/2", ok, r);
        end
        set_stat(1, 32'h0BAD_F00D);
        do_read(40'h804, d, r, ok, lat);
        n_checks++;
        if (!ok || d !== 32'h0BAD_F00D || r !== 2'b00) begin
            n_fail++; $display("FAIL rd804: got %h/%0d want 0badf00d/0", d, r);
        end
        do_read(40'h820, d, r, ok, lat);
        n_checks++;
        if (!ok || d !== 32'h0 || r !== 2'b10) begin
            n_fail++; $display("FAIL err_rd820: got %h/%0d want 0/2", d, r);
        end
        do_write(40'h020, $urandom, 4'hF, r, ok);
        n_checks++;
        if (!ok || r !== 2'b10) begin
            n_fail++; $display("FAIL err_wr020: got ok=%0d resp=%0d want 1/2", ok, r);
        end
    endtask

    task automatic test_same_edge();
        logic [31:0] old, nv;
        old = ctrl_m[5];
        nv = ~old ^ 32'h0F0F_1234;
        s_awaddr = 40'h14; s_wdata = nv; s_wstrb = 4'hF; s_araddr = 40'h14;
        s_awvalid = 1; s_wvalid = 1; s_arvalid = 1;
        @(posedge aclk); #1;
        s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
        model_write(40'h14, nv, 4'hF);
        n_checks++;
        if (s_rvalid !== 1'b1 || s_rdata !== old || s_bvalid !== 1'b1 || cq(5) !== nv) begin
            n_fail++; $display("FAIL same_edge: got rd=%h q=%h rv=%b bv=%b want %h/%h/1/1",
                               s_rdata, cq(5), s_rvalid, s_bvalid, old, nv);
        end
        s_bready = 1; s_rready = 1;
        @(posedge aclk); #1;
        s_bready = 0; s_rready = 0;
    endtask

    task automatic rand_addr(output logic [39:0] a);
        int k, off;
        k = $urandom_range(0, 9);
        if (k < 6)       off = 4 * $urandom_range(0, NC - 1);
        else if (k == 6) off = 4 * $urandom_range(NC, 511);
        else if (k == 7) off = 'h800 + 4 * $urandom_range(0, NS - 1);
        else if (k == 8) off = 'h800 + 4 * $urandom_range(NS, 510);
        else             off = 'hFFC;
        a[39:12] = 28'($urandom);
        a[11:0]  = 12'(off);
        a[1:0]   = 2'($urandom);
    endtask

    task automatic test_random();
        logic [39:0] a; logic [31:0] d, got; logic [3:0] s; logic [1:0] r; bit ok, lat, same;
        for (int it = 0; it < 60; it++) begin
            if (it % 7 == 0) set_stat($urandom_range(0, NS - 1), $urandom);
            rand_addr(a);
            d = $urandom; s = 4'($urandom);
            do_write(a, d, s, r, ok);
            n_checks++;
            if (!ok || r !== model_resp(a, 1)) begin
                n_fail++; $display("FAIL rnd_wresp%0d: addr %h got ok=%0d resp=%0d want %0d", it, a, ok, r, model_resp(a, 1));
            end
            model_write(a, d, s);
            same = 1;
            for (int i = 0; i < NC; i++) if (cq(i) !== ctrl_m[i]) same = 0;
            n_checks++;
            if (!same) begin
                n_fail++; $display("FAIL rnd_ctrl%0d: addr %h strb %h data %h ctrl_q mismatch", it, a, s, d);
            end
            rand_addr(a);
            do_read(a, got, r, ok, lat);
            n_checks++;
            if (!ok || !lat || got !== model_read(a) || r !== model_resp(a, 0)) begin
                n_fail++; $display("FAIL rnd_read%0d: addr %h got %h/%0d want %h/%0d", it, a, got, r,
                                   model_read(a), model_resp(a, 0));
            end
        end
    endtask

    task automatic test_reset_mid_write();
        bit same;
        s_awaddr = 40'h18; s_awvalid = 1;
        @(posedge aclk); #1;
        s_awvalid = 0;
        n_checks++;
        if (s_awready !== 1'b0) begin
            n_fail++; $display("FAIL mid_aw_held: got awready=%b want 0", s_awready);
        end
        #2 aresetn = 0;
        #1;
        model_reset();
        n_checks++;
        if (s_awready !== 1'b1) begin
            n_fail++; $display("FAIL mid_async_clear: got awready=%b want 1", s_awready);
        end
        @(posedge aclk); #1;
        aresetn = 1;
        @(posedge aclk); #1;
        s_wdata = $urandom; s_wstrb = 4'hF; s_wvalid = 1;
        @(posedge aclk); #1;
        s_wvalid = 0;
        n_checks++;
        if (s_wready !== 1'b0) begin
            n_fail++; $display("FAIL mid_w_held: got wready=%b want 0", s_wready);
        end
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if (s_bvalid !== 1'b0 || ctrl_wr !== '0) begin
                n_fail++; $display("FAIL mid_no_commit%0d: got bvalid=%b wr=%b want 0/0", c, s_bvalid, ctrl_wr);
            end
            @(posedge aclk); #1;
        end
        same = 1;
        for (int i = 0; i < NC; i++) if (cq(i) !== ctrl_m[i]) same = 0;
        n_checks++;
        if (!same) begin
            n_fail++; $display("FAIL mid_ctrl_reset: got reg6 %h want %h", cq(6), ctrl_m[6]);
        end
    endtask

    initial begin
        model_reset();
        for (int i = 0; i < NS; i++) set_stat(i, $urandom);
        test_reset();
        test_write_readback();
        test_decoupled();
        test_back_pressure();
        test_errors();
        test_same_edge();
        test_random();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
